debug_unit: RTL



---
 rtl/debug_unit_pkg.sv | 30 +++
 rtl/du_word_tx.sv | 63 ++++++
 rtl/debug_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/debug_unit_pkg.sv
// Shared constants and state encodings for the debug unit and its word serialiser.
package debug_unit_pkg;

    localparam int BYTE    = 8;
    localparam int DWORD   = 32;
    localparam int ADDR    = 7;
    localparam int RB_ADDR = 5;

    localparam logic [BYTE-1:0]  CMD_LOAD  = 8'd3;
    localparam logic [BYTE-1:0]  CMD_RUN   = 8'd7;
    localparam logic [BYTE-1:0]  CMD_STEP  = 8'd8;
    localparam logic [DWORD-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_WR,
        RUN,
        STEP,
        DUMP_PC,
        DUMP_RB_RD,
        DUMP_SEND
    } state_t;

    typedef enum logic {
        TX_IDLE,
        TX_WAIT
    } tx_state_t;

endpackage

// File: rtl/du_word_tx.sv
// Sends a latched 32-bit word as four bytes, MSB first, over the UART
// tx_start/tx_done handshake and pulses o_done after the last byte completes.
module du_word_tx
    import debug_unit_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [DWORD-1:0] i_word,
    input  logic             i_tx_done_tick,
    output logic [BYTE-1:0]  o_tx_data,
    output logic             o_tx_start,
    output logic             o_done
);

    tx_state_t        r_state;
    logic [DWORD-1:0] r_word;
    logic [1:0]       r_cnt;
    logic             r_tx_start;
    logic             r_done;

    assign o_tx_data  = r_word[DWORD-1 -: BYTE];
    assign o_tx_start = r_tx_start;
    assign o_done     = r_done;

    // A done tick that coincides with our own start pulse belongs to an older byte.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= TX_IDLE;
            r_word     <= '0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (i_start) begin
                        r_word     <= i_word;
                        r_cnt      <= '0;
                        r_tx_start <= 1'b1;
                        r_state    <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (i_tx_done_tick && !r_tx_start) begin
                        if (r_cnt == 2'd3) begin
                            r_done  <= 1'b1;
                            r_state <= TX_IDLE;
                        end else begin
                            r_word     <= r_word << BYTE;
                            r_cnt      <= r_cnt + 2'd1;
                            r_tx_start <= 1'b1;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_unit.sv
// UART command decoder: loads instruction memory, runs or single-steps the
// processor, then dumps PC and the register file back over the UART.
module debug_unit
    import debug_unit_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [BYTE-1:0]    i_rx_data,
    input  logic               i_rx_done_tick,
    input  logic               i_tx_done_tick,
    input  logic               i_halt,
    input  logic [DWORD-1:0]   i_pc,
    input  logic [DWORD-1:0]   i_rb_data,
    output logic [BYTE-1:0]    o_tx_data,
    output logic               o_tx_start,
    output logic               o_cpu_enable,
    output logic               o_cpu_flush,
    output logic               o_im_wr_en,
    output logic [ADDR-1:0]    o_im_addr,
    output logic [DWORD-1:0]   o_im_data,
    output logic [RB_ADDR-1:0] o_rb_addr
);

    localparam logic [ADDR-1:0]    IM_LAST = '1;
    localparam logic [RB_ADDR-1:0] RB_LAST = '1;

    state_t                r_state;
    logic [1:0]            r_byte_cnt;
    logic [DWORD-BYTE-1:0] r_shift;
    logic [DWORD-1:0]      r_pc;
    logic                  r_word_start;
    logic                  r_word_is_pc;
    logic                  r_cpu_enable;
    logic                  r_cpu_flush;
    logic                  r_im_wr_en;
    logic [ADDR-1:0]       r_im_addr;
    logic [DWORD-1:0]      r_im_data;
    logic [RB_ADDR-1:0]    r_rb_addr;

    logic [DWORD-1:0]      w_word;
    logic                  w_word_done;

    assign w_word       = r_word_is_pc ? r_pc : i_rb_data;
    assign o_cpu_enable = r_cpu_enable;
    assign o_cpu_flush  = r_cpu_flush;
    assign o_im_wr_en   = r_im_wr_en;
    assign o_im_addr    = r_im_addr;
    assign o_im_data    = r_im_data;
    assign o_rb_addr    = r_rb_addr;

    du_word_tx u_word_tx (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_start        (r_word_start),
        .i_word         (w_word),
        .i_tx_done_tick (i_tx_done_tick),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .o_done         (w_word_done)
    );

    // DUMP_RB_RD gives the register file its one cycle of read latency;
    // the word is then latched by the serialiser while r_word_start is high.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_pc         <= '0;
            r_word_start <= 1'b0;
            r_word_is_pc <= 1'b0;
            r_cpu_enable <= 1'b0;
            r_cpu_flush  <= 1'b0;
            r_im_wr_en   <= 1'b0;
            r_im_addr    <= '0;
            r_im_data    <= '0;
            r_rb_addr    <= '0;
        end else begin
            r_cpu_flush  <= 1'b0;
            r_im_wr_en   <= 1'b0;
            r_word_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_rx_done_tick) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                r_cpu_flush <= 1'b1;
                                r_im_addr   <= '0;
                                r_byte_cnt  <= '0;
                                r_state     <= LOAD;
                            end
                            CMD_RUN: begin
                                r_cpu_enable <= 1'b1;
                                r_state      <= RUN;
                            end
                            CMD_STEP: begin
                                if (i_halt) begin
                                    r_state <= DUMP_PC;
                                end else begin
                                    r_cpu_enable <= 1'b1;
                                    r_state      <= STEP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                LOAD: begin
                    if (i_rx_done_tick) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_im_data  <= {r_shift, i_rx_data};
                            r_im_wr_en <= 1'b1;
                            r_state    <= LOAD_WR;
                        end else begin
                            r_shift <= {r_shift[DWORD-2*BYTE-1:0], i_rx_data};
                        end
                    end
                end
                LOAD_WR: begin
                    if (r_im_addr != IM_LAST) begin
                        r_im_addr <= r_im_addr + ADDR'(1);
                    end
                    if (r_im_data == HALT_WORD || r_im_addr == IM_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                RUN: begin
                    if (i_halt) begin
                        r_cpu_enable <= 1'b0;
                        r_state      <= DUMP_PC;
                    end
                end
                STEP: begin
                    r_cpu_enable <= 1'b0;
                    r_state      <= DUMP_PC;
                end
                DUMP_PC: begin
                    r_pc         <= i_pc;
                    r_word_is_pc <= 1'b1;
                    r_word_start <= 1'b1;
                    r_rb_addr    <= '0;
                    r_state      <= DUMP_SEND;
                end
                DUMP_RB_RD: begin
                    r_word_start <= 1'b1;
                    r_state      <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (w_word_done) begin
                        if (r_word_is_pc) begin
                            r_word_is_pc <= 1'b0;
                            r_state      <= DUMP_RB_RD;
                        end else if (r_rb_addr == RB_LAST) begin
                            r_rb_addr <= '0;
                            r_state   <= IDLE;
                        end else begin
                            r_rb_addr <= r_rb_addr + RB_ADDR'(1);
                            r_state   <= DUMP_RB_RD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
